x25519_result_tx: RTL
=====================

Name: x25519_result_tx

Overview:
- Transmit side for the x25519 scalar-multiplication core's result.
- Captures the 255-bit x_q when the core's done rises and encodes it as the RFC 7748 256-bit little-endian u-coordinate (bit 255 = 0).
- Streams the encoding over a valid/ready byte-lane interface toward the host/bus side.
- Sits directly after scalar_multiplication; it is the mirror of the parallel k/x_p load interface.

Parameters:
- OUT_W, 8, beat width in bits; must divide 256 (8, 16, 32, 64 supported).
- BEATS, 256/OUT_W, derived localparam; number of beats per result.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- x_q  in  255  result from scalar multiplier; sampled only at done rising edge
- done  in  1  level from scalar multiplier; a 0->1 transition marks a new result
- m_data  out  OUT_W  current beat, least-significant beat first
- m_valid  out  1  beat valid
- m_last  out  1  high with final beat (beat BEATS-1)
- m_ready  in  1  sink accepts beat when m_valid & m_ready
- busy  out  1  high whenever state != IDLE
- overrun  out  1  sticky; set when a result is dropped; cleared only by rst

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, overrun=0, beat counter=0, state=IDLE.
- While rst is high, done_q <= done. A done level held through reset is therefore not a new edge.
- Edge detect: rise = done & ~done_q. done_q updates every cycle.
- FSM states: IDLE, REDUCE (only with the feature), SEND.
- IDLE:
  - On rise, load shift register with {1'b0, x_q} and clear the counter.
  - Go to SEND (or REDUCE with the feature).
- Latency: m_valid is high the cycle after rise (2 cycles with the feature).
- SEND:
  - m_data = shift[OUT_W-1:0].
  - m_valid, m_data and m_last are held stable while m_valid & ~m_ready.
  - On handshake: shift right by OUT_W and increment the counter.
  - m_last = (counter == BEATS-1).
  - After the last handshake: return to IDLE and drop m_valid the next cycle.
- rise while busy: the new result is dropped, overrun <= 1, and the current stream continues unchanged.
- Exception (back-to-back): rise coincident with the final handshake is accepted, not dropped.
  - The new value loads and m_valid stays high with its first beat.
  - With the feature, m_valid drops for exactly one cycle (REDUCE).
- m_ready is ignored when m_valid=0.
- Reset mid-stream: all outputs return to reset values next cycle. The partial stream is abandoned with no m_last.

Optional Feature:
- Macro: X25519_TX_REDUCE_EN.
- Defined:
  - REDUCE state (one cycle) applies the final canonical reduction: if value >= p (p = 2^255-19) then value - p.
  - This guarantees the output is in [0, p).
  - Latency from rise to first m_valid becomes 2 cycles.
- Undefined:
  - The raw captured x_q is streamed (may be in [p, 2^255)).
  - REDUCE state does not exist; latency is 1 cycle.

Decomposition:
- Package x25519_pkg:
  - FIELD_W=255, ENC_W=256, P_25519 = 2^255-19 as 255-bit constant.
  - State enum typedef for this block.
- Natural sub-module: x25519_final_reduce.
  - Combinational compare-and-conditional-subtract of p.
  - Instantiated only under X25519_TX_REDUCE_EN; reusable by other blocks.

Test Plan:
- x_q=9, done rise, m_ready=1, OUT_W=8:
  - m_valid high 1 cycle later.
  - Beats 0x09 then 31 x 0x00.
  - m_last only on beat 31.
  - busy falls after beat 31.
- x_q=2^255-18 (p+1):
  - With X25519_TX_REDUCE_EN: beats 0x01, 31 x 0x00.
  - Without it: beats 0xEE, 30 x 0xFF, 0x7F.
- Backpressure:
  - Hold m_ready=0 for 3 cycles at beat 5 of x_q=0x0102...20 pattern.
  - m_data and m_valid are stable for those cycles and no beat is skipped or duplicated.
- Overrun:
  - Second done rise (new x_q=1) during beat 10 -> overrun=1.
  - Original stream completes unchanged and no second stream follows.
- Back-to-back: second rise exactly on the final handshake -> second result streams immediately, overrun stays 0.
- Reset mid-stream:
  - Assert rst at beat 7 with done held high -> m_valid=0, busy=0 next cycle.
  - After deassert, no stream starts until done falls and rises again.
- Width check: OUT_W=32, x_q=9 -> 8 beats: 0x00000009, 7 x 0x00000000, m_last on beat 7.

Source files
------------

// File: rtl/x25519_pkg.sv
// Shared x25519 constants and the result-transmitter state encoding.
// X25519_TX_REDUCE_EN adds the REDUCE state used for the final canonical reduction.
package x25519_pkg;

  localparam int unsigned FIELD_W = 255;
  localparam int unsigned ENC_W   = 256;

  // p = 2^255 - 19 : low byte is 0xED, every other bit set
  localparam logic [FIELD_W-1:0] P_25519 = {{(FIELD_W-5){1'b1}}, 5'b01101};

`ifdef X25519_TX_REDUCE_EN
  typedef enum logic [1:0] {IDLE, REDUCE, SEND} tx_state_e;
`else
  typedef enum logic [0:0] {IDLE, SEND} tx_state_e;
`endif

endpackage

// File: rtl/x25519_result_tx_if.sv
// Valid/ready beat stream carrying the encoded u-coordinate toward the host side.
interface x25519_result_tx_if #(
  parameter int unsigned OUT_W = 8
) ();

  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_last;
  logic             m_ready;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/x25519_final_reduce.sv
// Combinational canonical reduction: maps [0, 2^255) onto [0, p) with one conditional subtract of p.
module x25519_final_reduce
  import x25519_pkg::*;
(
  input  logic [FIELD_W-1:0] val_i,
  output logic [FIELD_W-1:0] val_c_o
);

  // Inputs are below 2^255 < 2p, so a single subtract is always sufficient
  assign val_c_o = (val_i >= P_25519) ? (val_i - P_25519) : val_i;

endmodule

// File: rtl/x25519_result_tx.sv
// Captures the scalar multiplier result on a rising done and streams its 256-bit little-endian
// encoding LSB beat first. Define X25519_TX_REDUCE_EN to reduce the value mod p before sending.
module x25519_result_tx
  import x25519_pkg::*;
#(
  parameter int unsigned OUT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FIELD_W-1:0] x_q,
  input  logic               done,
  x25519_result_tx_if.master m_if,
  output logic               busy,
  output logic               overrun
);

  localparam int unsigned BEATS = ENC_W / OUT_W;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  tx_state_e        state_q;
  logic [ENC_W-1:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             m_valid_q;
  logic             m_last_q;
  logic             busy_q;
  logic             overrun_q;

  logic rise_c;
  assign rise_c = done & ~done_q;

`ifdef X25519_TX_REDUCE_EN
  logic [FIELD_W-1:0] red_c;

  x25519_final_reduce u_reduce (
    .val_i   (shift_q[FIELD_W-1:0]),
    .val_c_o (red_c)
  );
`endif

  // Capture, optional reduce, and beat-by-beat shift-out
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      cnt_q     <= '0;
      done_q    <= done;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= done;
      case (state_q)
        IDLE: begin
          if (rise_c) begin
            shift_q  <= {1'b0, x_q};
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            m_last_q <= 1'b0;
`ifdef X25519_TX_REDUCE_EN
            state_q   <= REDUCE;
            m_valid_q <= 1'b0;
`else
            state_q   <= SEND;
            m_valid_q <= 1'b1;
`endif
          end
        end
`ifdef X25519_TX_REDUCE_EN
        REDUCE: begin
          shift_q   <= {1'b0, red_c};
          state_q   <= SEND;
          m_valid_q <= 1'b1;
          m_last_q  <= 1'b0;
          if (rise_c) overrun_q <= 1'b1;
        end
`endif
        SEND: begin
          if (m_if.m_ready) begin
            if (cnt_q == LAST_BEAT) begin
              // A rise on the final handshake starts the next result back-to-back
              if (rise_c) begin
                shift_q  <= {1'b0, x_q};
                cnt_q    <= '0;
                m_last_q <= 1'b0;
`ifdef X25519_TX_REDUCE_EN
                state_q   <= REDUCE;
                m_valid_q <= 1'b0;
`else
                state_q   <= SEND;
                m_valid_q <= 1'b1;
`endif
              end else begin
                shift_q   <= shift_q >> OUT_W;
                cnt_q     <= '0;
                state_q   <= IDLE;
                m_valid_q <= 1'b0;
                m_last_q  <= 1'b0;
                busy_q    <= 1'b0;
              end
            end else begin
              shift_q  <= shift_q >> OUT_W;
              cnt_q    <= cnt_q + CNT_W'(1);
              m_last_q <= ((cnt_q + CNT_W'(1)) == LAST_BEAT);
              if (rise_c) overrun_q <= 1'b1;
            end
          end else if (rise_c) begin
            overrun_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          m_valid_q <= 1'b0;
          m_last_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign m_if.m_data  = shift_q[OUT_W-1:0];
  assign m_if.m_valid = m_valid_q;
  assign m_if.m_last  = m_last_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
